ramio_copier: RTL and testbench

//  Bus initiator for the ramio CPU-side port: copies a block of 32-bit words from src to dst via ramio.

---
 rtl/ramio_copier.sv | 154 +++++++++++++++
 tb/tb_ramio_copier.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ramio_copier.sv
// Block-copy bus initiator for the ramio CPU-side port.
// Copies 32-bit words from src to dst and keeps a running sum of every word read.
module ramio_copier #(
    parameter int CountBitWidth = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [31:0]              src_addr,
    input  logic [31:0]              dst_addr,
    input  logic [CountBitWidth-1:0] word_count,
    output logic                     active,
    output logic                     done,
    output logic [31:0]              checksum,
    output logic                     enable,
    output logic [2:0]               read_type,
    output logic [1:0]               write_type,
    output logic [31:0]              address,
    output logic [31:0]              data_in,
    input  logic [31:0]              data_out,
    input  logic                     data_out_ready,
    input  logic                     busy
);

    // state     | meaning
    // S_IDLE    | waiting for start
    // S_RD      | read request held on ramio until data_out_ready
    // S_WR      | single-cycle full-word write to dst
    // S_SETTLE  | one idle cycle while ramio raises busy for the write
    // S_WAIT    | wait for busy low, then step pointers and count
    // S_DONE    | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_SETTLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                   r_state, w_next;
    logic [31:0]              r_src, w_src;
    logic [31:0]              r_dst, w_dst;
    logic [CountBitWidth-1:0] r_rem, w_rem;
    logic [31:0]              r_word, w_word;
    logic [31:0]              r_sum, w_sum;
    logic                     r_active, w_active;
    logic                     r_done, w_done;
    logic                     r_enable, w_enable;
    logic [2:0]               r_read_type, w_read_type;
    logic [1:0]               r_write_type, w_write_type;
    logic [31:0]              r_address, w_address;
    logic [31:0]              r_data_in, w_data_in;

    always_comb begin
        w_next   = r_state;
        w_src    = r_src;
        w_dst    = r_dst;
        w_rem    = r_rem;
        w_word   = r_word;
        w_sum    = r_sum;
        w_active = r_active;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_src    = {src_addr[31:2], 2'b00};
                    w_dst    = {dst_addr[31:2], 2'b00};
                    w_rem    = word_count;
                    w_sum    = 32'd0;
                    w_active = 1'b1;
                    w_next   = (word_count == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                if (data_out_ready) begin
                    w_word = data_out;
                    w_sum  = r_sum + data_out;
                    w_next = S_WR;
                end
            end
            S_WR:     w_next = S_SETTLE;
            S_SETTLE: w_next = S_WAIT;
            S_WAIT: begin
                if (!busy) begin
                    w_rem  = r_rem - 1'b1;
                    w_src  = r_src + 32'd4;
                    w_dst  = r_dst + 32'd4;
                    w_next = (w_rem == '0) ? S_DONE : S_RD;
                end
            end
            S_DONE: begin
                w_active = 1'b0;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase

        // Bus outputs are registered from the next state so they line up with it.
        w_enable     = (w_next == S_RD) || (w_next == S_WR);
        w_read_type  = (w_next == S_RD) ? 3'b111 : 3'b000;
        w_write_type = (w_next == S_WR) ? 2'b11 : 2'b00;
        w_address    = r_address;
        w_data_in    = r_data_in;
        if (w_next == S_RD) begin
            w_address = w_src;
        end else if (w_next == S_WR) begin
            w_address = w_dst;
            w_data_in = w_word;
        end
        w_done = (w_next == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_src        <= 32'd0;
            r_dst        <= 32'd0;
            r_rem        <= '0;
            r_word       <= 32'd0;
            r_sum        <= 32'd0;
            r_active     <= 1'b0;
            r_done       <= 1'b0;
            r_enable     <= 1'b0;
            r_read_type  <= 3'b000;
            r_write_type <= 2'b00;
            r_address    <= 32'd0;
            r_data_in    <= 32'd0;
        end else begin
            r_state      <= w_next;
            r_src        <= w_src;
            r_dst        <= w_dst;
            r_rem        <= w_rem;
            r_word       <= w_word;
            r_sum        <= w_sum;
            r_active     <= w_active;
            r_done       <= w_done;
            r_enable     <= w_enable;
            r_read_type  <= w_read_type;
            r_write_type <= w_write_type;
            r_address    <= w_address;
            r_data_in    <= w_data_in;
        end
    end

    assign active     = r_active;
    assign done       = r_done;
    assign checksum   = r_sum;
    assign enable     = r_enable;
    assign read_type  = r_read_type;
    assign write_type = r_write_type;
    assign address    = r_address;
    assign data_in    = r_data_in;

endmodule

// File: tb/tb_ramio_copier.sv
// Bench for ramio_copier: behavioural ramio responder plus an array-based copy model.
module tb_ramio_copier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = 32'd0;
    logic [31:0] dst_addr = 32'd0;
    logic [15:0] word_count = 16'd0;
    logic        active, done, enable;
    logic [31:0] checksum, address, data_in;
    logic [2:0]  read_type;
    logic [1:0]  write_type;
    logic [31:0] data_out = 32'd0;
    logic        data_out_ready = 1'b0;
    logic        busy = 1'b0;

    ramio_copier #(.CountBitWidth(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
        .active(active), .done(done), .checksum(checksum),
        .enable(enable), .read_type(read_type), .write_type(write_type),
        .address(address), .data_in(data_in),
        .data_out(data_out), .data_out_ready(data_out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // ramio stand-in: 64-word memory, random read latency, random busy after writes
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        fill_req = 1'b1;
    int          busy_min = 0;
    logic        rd_pend = 1'b0, cool = 1'b0;
    int          rd_cnt = 0, busy_cnt = 0, len = 0;
    logic [31:0] rd_addr = 32'd0;
    logic [31:0] wr_q [$];
    logic [31:0] exp_q [$];
    int          done_cnt = 0, en_cnt = 0;

    always @(posedge clk) begin
        data_out_ready <= 1'b0;
        if (fill_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= $urandom;
            mem[4] <= 32'hD5B8A9C4;
        end else if (!rst_n) begin
            rd_pend  <= 1'b0;
            cool     <= 1'b0;
            busy     <= 1'b0;
            busy_cnt <= 0;
        end else begin
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    data_out       <= mem[rd_addr[7:2]];
                    data_out_ready <= 1'b1;
                    rd_pend        <= 1'b0;
                    cool           <= 1'b1;
                end else begin
                    rd_cnt <= rd_cnt - 1;
                end
            end else if (cool) begin
                cool <= 1'b0;
            end else if (enable && read_type == 3'b111 && write_type == 2'b00) begin
                rd_pend <= 1'b1;
                rd_cnt  <= $urandom_range(0, 5);
                rd_addr <= address;
            end
            if (enable && write_type == 2'b11 && read_type == 3'b000) begin
                mem[address[7:2]] <= data_in;
                wr_q.push_back(address);
                len = busy_min + $urandom_range(0, 3);
                busy_cnt <= len;
                busy     <= (len != 0);
            end else if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
                busy     <= (busy_cnt > 1);
            end
        end
    end

    always @(posedge clk) begin
        if (done)   done_cnt <= done_cnt + 1;
        if (enable) en_cnt   <= en_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: ascending word copy on the model array, sum of words as read.
    task automatic ref_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            output logic [31:0] sum);
        logic [31:0] sa, da, w;
        sa = {s[31:2], 2'b00};
        da = {d[31:2], 2'b00};
        sum = 32'd0;
        for (int i = 0; i < n; i++) begin
            w = ref_mem[sa[7:2]];
            ref_mem[da[7:2]] = w;
            sum = sum + w;
            exp_q.push_back(da);
            sa = sa + 32'd4;
            da = da + 32'd4;
        end
    endtask

    task automatic sync_ref();
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    endtask

    task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int n,
                           input bit extra, input string nm, output logic [31:0] sum_got);
        logic [31:0] exp_sum;
        int d0, e0, w0, cyc, mm;
        bit got;
        d0 = done_cnt; e0 = en_cnt; w0 = wr_q.size();
        exp_q.delete();
        ref_copy(s, d, n, exp_sum);
        @(negedge clk);
        src_addr = s; dst_addr = d; word_count = 16'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_active"}, {31'd0, active}, 32'd1);
        cyc = 1;
        got = done;
        while (!got && cyc < 3000) begin
            if (extra && cyc == 3) begin
                start = 1'b1; src_addr = 32'h40; dst_addr = 32'h0; word_count = 16'd3;
            end
            if (extra && cyc == 4) start = 1'b0;
            @(negedge clk);
            cyc++;
            got = done;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL %s_timeout: no done after %0d cycles, required one", nm, cyc);
        end
        sum_got = checksum;
        chk({nm, "_checksum"}, checksum, exp_sum);
        if (n == 0) begin
            chk({nm, "_latency_le2"}, {31'd0, cyc <= 2}, 32'd1);
            chk({nm, "_no_enable"}, en_cnt - e0, 32'd0);
        end
        @(negedge clk);
        chk({nm, "_done_low"}, {31'd0, done}, 32'd0);
        chk({nm, "_active_low"}, {31'd0, active}, 32'd0);
        chk({nm, "_done_pulses"}, done_cnt - d0, 32'd1);
        chk({nm, "_writes"}, wr_q.size() - w0, n);
        for (int i = 0; i < n && (w0 + i) < wr_q.size(); i++)
            chk({nm, "_wr_addr"}, wr_q[w0 + i], exp_q[i]);
        mm = -1;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i] && mm < 0) mm = i;
        if (mm < 0) chk({nm, "_mem"}, 32'd0, 32'd0 + (mm < 0 ? 0 : 1));
        else chk({nm, "_mem"}, mem[mm], ref_mem[mm]);
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          cnt;
        bit          extra;
        bit          has_sum;
        logic [31:0] sum;
        string       nm;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [31:0] sg, pre_src, old_dst;
        int d0, n_wait;
        vecs[0] = '{32'd16, 32'd48, 1, 1'b0, 1'b1, 32'hD5B8A9C4, "one_word"};
        vecs[1] = '{32'd16, 32'd48, 0, 1'b0, 1'b1, 32'h0, "zero_count"};
        vecs[2] = '{32'd16, 32'd80, 4, 1'b0, 1'b0, 32'h0, "four_words"};
        vecs[3] = '{32'd17, 32'd50, 1, 1'b0, 1'b1, 32'hD5B8A9C4, "unaligned"};
        vecs[4] = '{32'd16, 32'd80, 4, 1'b1, 1'b0, 32'h0, "restart_ignored"};
        vecs[5] = '{32'hFFFF_FFF8, 32'd128, 4, 1'b0, 1'b0, 32'h0, "addr_wrap"};
        vecs[6] = '{32'd0, 32'd8, 4, 1'b0, 1'b0, 32'h0, "overlap"};

        repeat (3) @(negedge clk);
        fill_req = 1'b0;
        @(negedge clk);
        chk("rst_enable", {31'd0, enable}, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        chk("rst_types", {27'd0, read_type, write_type}, 32'd0);
        chk("rst_address", address, 32'd0);
        sync_ref();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            run_job(vecs[v].src, vecs[v].dst, vecs[v].cnt, vecs[v].extra, vecs[v].nm, sg);
            if (vecs[v].has_sum) chk({vecs[v].nm, "_golden_sum"}, sg, vecs[v].sum);
        end
        chk("golden_dst48", mem[12], 32'hD5B8A9C4);

        for (int r = 0; r < 8; r++) begin
            busy_min = $urandom_range(0, 2);
            run_job($urandom & 32'hFF, $urandom & 32'hFF, $urandom_range(1, 6), 1'b0, "random", sg);
        end

        // Reset while waiting out a write's busy period.
        busy_min = 4;
        pre_src = mem[8];
        old_dst = mem[40];
        d0 = done_cnt;
        @(negedge clk);
        src_addr = 32'd32; dst_addr = 32'd160; word_count = 16'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_wait = 0;
        while (!busy && n_wait < 500) begin
            @(negedge clk);
            n_wait++;
        end
        if (!busy) begin
            total++; bad++;
            $display("FAIL rstmid_busy_wait: busy never seen, required high");
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_enable", {31'd0, enable}, 32'd0);
        chk("rstmid_active", {31'd0, active}, 32'd0);
        chk("rstmid_done", {31'd0, done}, 32'd0);
        chk("rstmid_checksum", checksum, 32'd0);
        repeat (2) @(negedge clk);
        chk("rstmid_no_done", done_cnt - d0, 32'd0);
        chk("rstmid_partial", mem[40], pre_src);
        rst_n = 1'b1;
        busy_min = 1;
        @(negedge clk);
        sync_ref();
        run_job(32'd32, 32'd160, 4, 1'b0, "after_reset", sg);
        if (old_dst === pre_src) chk("rstmid_dst_changed_dummy", sg, sg + 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
